// File: rtl/sched_pkg.sv
// Shared types for the task batch scheduler.
//   top_state_e  : batch-level FSM states
//   slot_state_e : per-child slot FSM states. The encoding is fixed so the
//                  slot state can be read directly on a debug bus.
package sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    NEXT   = 3'd3,
    FINISH = 3'd4
  } top_state_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_RUN   = 2'b11,
    S_DONE  = 2'b10
  } slot_state_e;

endpackage

// File: rtl/task_slot_fsm.sv
// Per-child ap_ctrl handshake slot.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   go        : one-cycle launch request from the batch FSM
//   clear     : return to S_IDLE (issued in NEXT and FINISH); overrides all
//   ready     : child ap_ready, honoured only in S_START
//   done      : child ap_done, honoured only in S_START / S_RUN
//   start     : child ap_start, high only in S_START
//   is_done   : slot has seen the child finish this iteration
module task_slot_fsm
  import sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic clear,
  input  logic ready,
  input  logic done,
  output logic start,
  output logic is_done
);

  slot_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) state_d = S_START;
        end
        S_START: begin
          // ap_start is held until the child accepts; done in the same
          // cycle as ready means the child finished immediately.
          if (ready) state_d = done ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (done) state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign start   = (state_q == S_START);
  assign is_done = (state_q == S_DONE);

endmodule

// File: rtl/task_batch_scheduler.sv
// Batch-level ap_ctrl controller: runs NUM_TASKS children in lock-step for
// batch_count iterations behind a single host ap_start/ap_done.
// Ports:
//   ap_clk, ap_rst       : clock, synchronous active-high reset
//   ap_start             : host start (level, sampled in IDLE)
//   ap_ready, ap_done    : one-cycle completion pulse (identical)
//   ap_idle              : high while the batch FSM is in IDLE
//   batch_count          : iterations to run, captured on start
//   iter_idx             : 0-based index of the current iteration
//   task_start           : per-child ap_start
//   task_ready/done/idle : per-child ap_ready/ap_done/ap_idle (idle unused)
//   err_timeout          : watchdog fired, sticky until next accepted start
// Optional feature: define SCHED_WATCHDOG_EN to enable the per-iteration
// watchdog of WDOG_CYCLES cycles; otherwise err_timeout is tied low.
module task_batch_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned NUM_TASKS   = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WDOG_CYCLES = 65535
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  output logic                 ap_ready,
  output logic                 ap_done,
  output logic                 ap_idle,
  input  logic [CNT_W-1:0]     batch_count,
  output logic [CNT_W-1:0]     iter_idx,
  output logic [NUM_TASKS-1:0] task_start,
  input  logic [NUM_TASKS-1:0] task_ready,
  input  logic [NUM_TASKS-1:0] task_done,
  input  logic [NUM_TASKS-1:0] task_idle,
  output logic                 err_timeout
);

  top_state_e state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] iter_q, iter_d;

  logic                 slot_go;
  logic                 slot_clear;
  logic [NUM_TASKS-1:0] slot_done;
  logic                 all_done;
  logic                 wdog_fire;
  logic                 set_err;
  logic                 clear_err;

  // task_idle is status only and never gates sequencing.
  logic unused_task_idle;
  assign unused_task_idle = ^task_idle;

  for (genvar i = 0; i < NUM_TASKS; i++) begin : g_slot
    task_slot_fsm u_slot (
      .clk     (ap_clk),
      .rst     (ap_rst),
      .go      (slot_go),
      .clear   (slot_clear),
      .ready   (task_ready[i]),
      .done    (task_done[i]),
      .start   (task_start[i]),
      .is_done (slot_done[i])
    );
  end

  assign all_done = &slot_done;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      iter_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      iter_q      <= iter_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    iter_d      = iter_q;
    slot_go     = 1'b0;
    slot_clear  = 1'b0;
    set_err     = 1'b0;
    clear_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          remaining_d = batch_count;
          iter_d      = '0;
          clear_err   = 1'b1;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        if (remaining_q == '0) begin
          state_d = FINISH;
        end else begin
          slot_go = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Completion wins over a watchdog expiry in the same cycle.
        if (all_done) begin
          state_d = (remaining_q == CNT_W'(1)) ? FINISH : NEXT;
        end else if (wdog_fire) begin
          set_err = 1'b1;
          state_d = FINISH;
        end
      end
      NEXT: begin
        remaining_d = remaining_q - CNT_W'(1);
        iter_d      = iter_q + CNT_W'(1);
        slot_clear  = 1'b1;
        state_d     = LAUNCH;
      end
      FINISH: begin
        slot_clear = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ap_done  = (state_q == FINISH);
  assign ap_ready = ap_done;
  assign ap_idle  = (state_q == IDLE);
  assign iter_idx = iter_q;

`ifdef SCHED_WATCHDOG_EN
  localparam int unsigned WdogW = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES + 1);

  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             err_q, err_d;

  assign wdog_fire = (state_q == WAIT) && (wdog_q == WdogW'(WDOG_CYCLES));

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == LAUNCH) begin
      wdog_d = '0;
    end else if (state_q == WAIT && !wdog_fire) begin
      wdog_d = wdog_q + WdogW'(1);
    end
  end

  always_comb begin
    err_d = err_q;
    if (clear_err) begin
      err_d = 1'b0;
    end else if (set_err) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  localparam int unsigned UnusedWdogCycles = WDOG_CYCLES;
  logic unused_err_ctrl;
  assign unused_err_ctrl = set_err ^ clear_err ^ (UnusedWdogCycles == 0);
  assign wdog_fire       = 1'b0;
  assign err_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_task_batch_scheduler.sv
// Directed self-checking bench for task_batch_scheduler.
// Cycle numbering: T0 is the cycle in which ap_start is presented; Tn is
// the cycle after the n-th following rising edge. Outputs are sampled and
// inputs driven on the falling edge.
module tb_task_batch_scheduler;

  localparam int unsigned NT = 4;
  localparam int unsigned CW = 16;
  localparam int NEVER = 255;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          ap_start = 1'b0;
  logic          ap_ready, ap_done, ap_idle;
  logic [CW-1:0] batch_count = '0;
  logic [CW-1:0] iter_idx;
  logic [NT-1:0] task_start;
  logic [NT-1:0] task_ready = '0;
  logic [NT-1:0] task_done = '0;
  logic [NT-1:0] task_idle = '1;
  logic          err_timeout;

  int checks = 0;
  int errors = 0;

  // Child response schedule: 0 = always asserted, NEVER = never, else only in that cycle.
  int rdy_at[NT];
  int done_at[NT];

  logic [NT-1:0] rec_start[64];
  logic [CW-1:0] rec_iter[64];
  logic          rec_idle[64];
  logic          rec_ready[64];
  logic          rec_err[64];
  int            done_cyc;

  always #5 ap_clk = ~ap_clk;

  task_batch_scheduler #(
    .NUM_TASKS   (NT),
    .CNT_W       (CW),
    .WDOG_CYCLES (10)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .batch_count (batch_count),
    .iter_idx    (iter_idx),
    .task_start  (task_start),
    .task_ready  (task_ready),
    .task_done   (task_done),
    .task_idle   (task_idle),
    .err_timeout (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  function automatic logic sched_val(input int at, input int c);
    return (at == 0) ? 1'b1 : (at == c);
  endfunction

  task automatic drive_children(input int c);
    for (int i = 0; i < NT; i++) begin
      task_ready[i] = sched_val(rdy_at[i], c);
      task_done[i]  = sched_val(done_at[i], c);
    end
  endtask

  task automatic set_children(input int rdy, input int dn);
    for (int i = 0; i < NT; i++) begin
      rdy_at[i]  = rdy;
      done_at[i] = dn;
    end
  endtask

  // Present ap_start for one cycle and record outputs until one cycle past ap_done.
  task automatic run_batch(input int cnt, input int max_cyc);
    for (int k = 0; k < 64; k++) begin
      rec_start[k] = '0;
      rec_iter[k]  = '0;
      rec_idle[k]  = 1'b0;
      rec_ready[k] = 1'b0;
      rec_err[k]   = 1'b0;
    end
    done_cyc    = -1;
    batch_count = CW'(cnt);
    ap_start    = 1'b1;
    drive_children(0);
    for (int c = 1; c <= max_cyc; c++) begin
      step();
      ap_start     = 1'b0;
      rec_start[c] = task_start;
      rec_iter[c]  = iter_idx;
      rec_idle[c]  = ap_idle;
      rec_ready[c] = ap_ready;
      rec_err[c]   = err_timeout;
      if (ap_done && done_cyc < 0) done_cyc = c;
      drive_children(c);
      if (done_cyc >= 0 && c > done_cyc) break;
    end
  endtask

  function automatic int count_start_cycles(input int upto);
    int n = 0;
    for (int k = 1; k <= upto; k++) if (rec_start[k] != '0) n++;
    return n;
  endfunction

  initial begin
    set_children(0, 0);
    drive_children(0);
    step();
    step();
    check("rst_idle", 32'(ap_idle), 32'd1);
    check("rst_done", 32'(ap_done), 32'd0);
    check("rst_ready", 32'(ap_ready), 32'd0);
    check("rst_start", 32'(task_start), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_iter", 32'(iter_idx), 32'd0);
    ap_rst = 1'b0;
    step();

    // 1: single iteration, zero-latency children.
    run_batch(1, 20);
    check("t1_start_T1", 32'(rec_start[1]), 32'h0);
    check("t1_idle_T1", 32'(rec_idle[1]), 32'd0);
    check("t1_start_T2", 32'(rec_start[2]), 32'hF);
    check("t1_start_cnt", 32'(count_start_cycles(20)), 32'd1);
    check("t1_done_cyc", 32'(done_cyc), 32'd4);
    check("t1_ready_T4", 32'(rec_ready[4]), 32'd1);
    check("t1_idle_T5", 32'(rec_idle[5]), 32'd1);

    // 2: three iterations.
    run_batch(3, 30);
    check("t2_done_cyc", 32'(done_cyc), 32'd12);
    check("t2_iter_T2", 32'(rec_iter[2]), 32'd0);
    check("t2_iter_T6", 32'(rec_iter[6]), 32'd1);
    check("t2_iter_T10", 32'(rec_iter[10]), 32'd2);
    check("t2_start_cnt", 32'(count_start_cycles(30)), 32'd3);
    check("t2_start_T6", 32'(rec_start[6]), 32'hF);

    // 3: empty batch.
    run_batch(0, 20);
    check("t3_start_cnt", 32'(count_start_cycles(20)), 32'd0);
    check("t3_done_cyc", 32'(done_cyc), 32'd2);

    // 4: child1 ready at T4, done at T20.
    rdy_at[1]  = 4;
    done_at[1] = 20;
    run_batch(1, 40);
    check("t4_c1_T2", 32'(rec_start[2][1]), 32'd1);
    check("t4_c1_T4", 32'(rec_start[4][1]), 32'd1);
    check("t4_c1_T5", 32'(rec_start[5][1]), 32'd0);
    check("t4_c0_T3", 32'(rec_start[3][0]), 32'd0);
    check("t4_done_cyc", 32'(done_cyc), 32'd22);
    check("t4_err", 32'(rec_err[22]), 32'd0);

    // 5: reset in WAIT of iteration 1 of 3, then a clean rerun.
    set_children(NEVER, NEVER);
    drive_children(0);
    batch_count = CW'(3);
    ap_start    = 1'b1;
    step();
    ap_start = 1'b0;
    step();
    step();
    step();
    check("t5_start_wait", 32'(task_start), 32'hF);
    ap_rst = 1'b1;
    step();
    check("t5_rst_start", 32'(task_start), 32'h0);
    check("t5_rst_idle", 32'(ap_idle), 32'd1);
    check("t5_rst_iter", 32'(iter_idx), 32'd0);
    ap_rst = 1'b0;
    set_children(0, 0);
    run_batch(3, 30);
    check("t5_rerun_done", 32'(done_cyc), 32'd12);
    check("t5_rerun_cnt", 32'(count_start_cycles(30)), 32'd3);

`ifdef SCHED_WATCHDOG_EN
    // 6: child2 never done; watchdog of 10 cycles.
    done_at[2] = NEVER;
    run_batch(1, 40);
    check("t6_done_cyc", 32'(done_cyc), 32'd13);
    check("t6_err_T13", 32'(rec_err[13]), 32'd1);
    check("t6_err_T12", 32'(rec_err[12]), 32'd0);
    set_children(0, 0);
    run_batch(1, 20);
    check("t6_err_clear", 32'(rec_err[1]), 32'd0);
    check("t6_next_done", 32'(done_cyc), 32'd4);
`else
    check("t6_err_tied", 32'(err_timeout), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
